// File: rtl/mem_line_arbiter_if.sv
// mem_line_arbiter_if: bundles the icache/dcache request and response channels, the shared
// main-memory beat port and the arbiter status flags.
//   slave  : the arbiter's view (takes cache requests, drives memory requests and responses)
//   master : the environment's view (caches + memory model)
// Channels: ic_req_* / ic_rsp_*  icache line reads
//           dc_req_* / dc_rsp_*  dcache line fills and write-backs (dc_wdata / dc_wbeat_ack)
//           mem_req_* / mem_rsp_* single 128-bit memory beat port
//           busy, err             arbiter status
interface mem_line_arbiter_if #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 128
);
    logic          ic_req_valid;
    logic          ic_req_ready;
    logic [AW-1:0] ic_req_addr;
    logic          ic_rsp_valid;
    logic          ic_rsp_last;
    logic [DW-1:0] ic_rsp_data;

    logic          dc_req_valid;
    logic          dc_req_ready;
    logic          dc_req_we;
    logic [AW-1:0] dc_req_addr;
    logic [DW-1:0] dc_wdata;
    logic          dc_wbeat_ack;
    logic          dc_rsp_valid;
    logic          dc_rsp_last;
    logic [DW-1:0] dc_rsp_data;

    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_we;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;

    logic          busy;
    logic          err;

    modport slave (
        input  ic_req_valid, ic_req_addr,
        input  dc_req_valid, dc_req_we, dc_req_addr, dc_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output ic_req_ready, ic_rsp_valid, ic_rsp_last, ic_rsp_data,
        output dc_req_ready, dc_wbeat_ack, dc_rsp_valid, dc_rsp_last, dc_rsp_data,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output busy, err
    );

    modport master (
        output ic_req_valid, ic_req_addr,
        output dc_req_valid, dc_req_we, dc_req_addr, dc_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  ic_req_ready, ic_rsp_valid, ic_rsp_last, ic_rsp_data,
        input  dc_req_ready, dc_wbeat_ack, dc_rsp_valid, dc_rsp_last, dc_rsp_data,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  busy, err
    );
endinterface

// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: shares the single main-memory beat port between icache line fills and
// dcache fills / write-backs. One cache line is moved as BEATS ascending beats; read beats are
// forwarded straight back to the line's owner.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset; aborts any transfer in flight
//   bus  mem_line_arbiter_if.slave (cache request/response channels, memory port, busy/err)
// Parameters: AW beat-address width, DW data width, BEATS beats per line (power of 2, >=2),
//   DC_PRIO 1: dcache wins every tie, 0: round-robin on tie.
module mem_line_arbiter #(
    parameter int unsigned AW      = 12,
    parameter int unsigned DW      = 128,
    parameter int unsigned BEATS   = 4,
    parameter bit          DC_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    mem_line_arbiter_if.slave bus
);
    localparam int unsigned LW = $clog2(BEATS);
    // Request counter needs one extra bit so it can sit at BEATS once every beat is issued.
    localparam int unsigned CW = LW + 1;
    localparam logic [CW-1:0] ReqCntEnd = CW'(BEATS);
    localparam logic [CW-1:0] ReqCntLast = CW'(BEATS - 1);
    localparam logic [LW-1:0] RspCntLast = LW'(BEATS - 1);

    typedef enum logic [1:0] {StIdle, StIcRd, StDcRd, StDcWr} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [CW-1:0]    r_req_cnt;
    logic [LW-1:0]    r_rsp_cnt;
    logic             r_last_grant_dc;
    logic [AW-LW-1:0] r_base;
    logic             r_err;

    logic             w_grant_ic;
    logic             w_grant_dc;
    logic             w_rd;
    logic             w_req_pending;
    logic             w_req_fire;
    logic             w_rsp_last;
    logic             w_wr_done;
    logic [DW-1:0]    w_rsp_data;
    logic             w_unused;

    // Beat index bits of the request addresses are replaced by the beat counter.
    assign w_unused = ^{bus.ic_req_addr[LW-1:0], bus.dc_req_addr[LW-1:0]};

    // Arbitration: only evaluated in IDLE; on a tie the side that did not win last time goes,
    // unless DC_PRIO pins the tie to the dcache.
    always_comb begin
        w_grant_dc = 1'b0;
        w_grant_ic = 1'b0;
        if (r_state == StIdle && !rst) begin
            w_grant_dc = bus.dc_req_valid &&
                         (!bus.ic_req_valid || DC_PRIO || !r_last_grant_dc);
            w_grant_ic = bus.ic_req_valid && !w_grant_dc;
        end
    end

    assign w_rd          = (r_state == StIcRd) || (r_state == StDcRd);
    assign w_req_pending = r_req_cnt < ReqCntEnd;
    assign w_req_fire    = bus.mem_req_valid && bus.mem_req_ready;
    assign w_rsp_last    = w_rd && bus.mem_rsp_valid && (r_rsp_cnt == RspCntLast);
    assign w_wr_done     = (r_state == StDcWr) && bus.mem_req_ready && (r_req_cnt == ReqCntLast);
    assign w_rsp_data    = bus.mem_rsp_valid ? bus.mem_rsp_data : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_grant_dc) begin
                    w_state_next = bus.dc_req_we ? StDcWr : StDcRd;
                end else if (w_grant_ic) begin
                    w_state_next = StIcRd;
                end
            end
            StIcRd, StDcRd: begin
                if (w_rsp_last) begin
                    w_state_next = StIdle;
                end
            end
            StDcWr: begin
                if (w_wr_done) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Beat counters, latched line base, grant history and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_cnt       <= '0;
            r_rsp_cnt       <= '0;
            r_last_grant_dc <= 1'b0;
            r_base          <= '0;
            r_err           <= 1'b0;
        end else begin
            if (w_rsp_last || w_wr_done) begin
                r_req_cnt <= '0;
                r_rsp_cnt <= '0;
            end else begin
                if (w_req_fire) begin
                    r_req_cnt <= r_req_cnt + 1'b1;
                end
                if (w_rd && bus.mem_rsp_valid) begin
                    r_rsp_cnt <= r_rsp_cnt + 1'b1;
                end
            end
            if (w_grant_dc) begin
                r_base          <= bus.dc_req_addr[AW-1:LW];
                r_last_grant_dc <= 1'b1;
            end else if (w_grant_ic) begin
                r_base          <= bus.ic_req_addr[AW-1:LW];
                r_last_grant_dc <= 1'b0;
            end
            // A response with no read transfer open can only be a protocol fault.
            if (bus.mem_rsp_valid && !w_rd) begin
                r_err <= 1'b1;
            end
        end
    end

    // Outputs.
    always_comb begin
        bus.ic_req_ready  = w_grant_ic;
        bus.dc_req_ready  = w_grant_dc;
        bus.ic_rsp_valid  = 1'b0;
        bus.ic_rsp_last   = 1'b0;
        bus.ic_rsp_data   = '0;
        bus.dc_rsp_valid  = 1'b0;
        bus.dc_rsp_last   = 1'b0;
        bus.dc_rsp_data   = '0;
        bus.dc_wbeat_ack  = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_we    = 1'b0;
        bus.mem_req_addr  = '0;
        bus.mem_req_wdata = '0;
        bus.busy          = r_state != StIdle;
        bus.err           = r_err;
        unique case (r_state)
            StIcRd: begin
                bus.mem_req_valid = w_req_pending;
                bus.ic_rsp_valid  = bus.mem_rsp_valid;
                bus.ic_rsp_last   = w_rsp_last;
                bus.ic_rsp_data   = w_rsp_data;
            end
            StDcRd: begin
                bus.mem_req_valid = w_req_pending;
                bus.dc_rsp_valid  = bus.mem_rsp_valid;
                bus.dc_rsp_last   = w_rsp_last;
                bus.dc_rsp_data   = w_rsp_data;
            end
            StDcWr: begin
                // The counter never reaches BEATS here: the last accepted beat leaves the state.
                bus.mem_req_valid = 1'b1;
                bus.mem_req_we    = 1'b1;
                bus.mem_req_wdata = bus.dc_wdata;
                bus.dc_wbeat_ack  = bus.mem_req_ready;
            end
            default: ;
        endcase
        if (bus.mem_req_valid) begin
            bus.mem_req_addr = {r_base, r_req_cnt[LW-1:0]};
        end
    end
endmodule

// File: tb/tb_mem_line_arbiter.sv
module tb_mem_line_arbiter;
    localparam int unsigned AW      = 12;
    localparam int unsigned DW      = 128;
    localparam int unsigned BEATS   = 4;
    localparam bit          DC_PRIO = 1'b0;

    typedef logic [DW-1:0] word_t;

    typedef struct {
        bit            do_ic;
        logic [AW-1:0] ia;
        bit            do_dc;
        bit            dwe;
        logic [AW-1:0] da;
        int            lat;
        bit            bp;
        bit            exp_first_dc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_line_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_line_arbiter #(
        .AW(AW), .DW(DW), .BEATS(BEATS), .DC_PRIO(DC_PRIO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    word_t got_ic_data[$], got_ic_last[$], got_dc_data[$], got_dc_last[$];
    word_t got_rd_addr[$], got_wr_addr[$], got_wr_data[$];
    int    grants[$];
    int    n_acks  = 0;
    bit    ack_seen = 1'b0;

    logic [AW-1:0] pend_addr[$];
    int            pend_due[$];
    int            lat      = 1;
    bit            rdy_rand = 1'b0;
    bit            rdy_pat[$];
    bit            inject   = 1'b0;

    logic [AW-1:0] wtag = '0;
    int            widx = 0;
    bit            m_last_dc = 1'b0;

    function automatic word_t memval(input logic [AW-1:0] a);
        return {4{20'hC0FFE, a}};
    endfunction

    function automatic word_t wpat(input logic [AW-1:0] tag, input int idx);
        logic [1:0] i2;
        i2 = 2'(idx);
        return {4{16'hBEEF, tag, i2, 2'b01}};
    endfunction

    assign bus.dc_wdata = wpat(wtag, widx);

    task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_q(input string name, input word_t got[$], input word_t exp[$]);
        chk({name, "_count"}, (DW+1)'(got.size()), (DW+1)'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk(name, {1'b0, got[i]}, {1'b0, exp[i]});
        end
    endtask

    // Memory model + dcache write-beat source; drives fresh values just after each rising edge.
    initial begin
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (ack_seen) widx++;
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = '0;
            if (inject) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = memval(12'hABC);
                inject = 1'b0;
            end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = memval(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (rdy_pat.size() > 0) bus.mem_req_ready = rdy_pat.pop_front();
            else if (rdy_rand) bus.mem_req_ready = ($urandom_range(3) != 0);
            else bus.mem_req_ready = 1'b1;
        end
    end

    // Monitor: collects completed handshakes and checks per-cycle output rules mid-cycle.
    always @(negedge clk) begin
        ack_seen = 1'b0;
        if (!rst) begin
            if (bus.ic_rsp_valid) begin
                got_ic_data.push_back(bus.ic_rsp_data);
                got_ic_last.push_back(word_t'(bus.ic_rsp_last));
            end
            if (bus.dc_rsp_valid) begin
                got_dc_data.push_back(bus.dc_rsp_data);
                got_dc_last.push_back(word_t'(bus.dc_rsp_last));
            end
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                if (bus.mem_req_we) begin
                    got_wr_addr.push_back(word_t'(bus.mem_req_addr));
                    got_wr_data.push_back(bus.mem_req_wdata);
                end else begin
                    got_rd_addr.push_back(word_t'(bus.mem_req_addr));
                    pend_addr.push_back(bus.mem_req_addr);
                    pend_due.push_back(cyc + lat);
                end
            end
            if (bus.dc_wbeat_ack) begin
                ack_seen = 1'b1;
                n_acks++;
            end
            if (!bus.ic_rsp_valid) chk("ic_rsp_quiet", {bus.ic_rsp_last, bus.ic_rsp_data}, '0);
            if (!bus.dc_rsp_valid) chk("dc_rsp_quiet", {bus.dc_rsp_last, bus.dc_rsp_data}, '0);
            chk("single_ready", (DW+1)'(bus.ic_req_ready & bus.dc_req_ready), '0);
            chk("req_only_busy", (DW+1)'(bus.mem_req_valid & ~bus.busy), '0);
        end
    end

    // Presents both requests, holds each until accepted, then waits for the arbiter to go idle.
    task automatic issue(input bit do_ic, input logic [AW-1:0] ia, input bit do_dc,
                         input bit dwe, input logic [AW-1:0] da, input int lat_i, input bit rr);
        bit pic, pdc, dic, ddc;
        int t;
        @(posedge clk);
        #1;
        lat      = lat_i;
        rdy_rand = rr;
        wtag     = da;
        widx     = 0;
        bus.ic_req_valid = do_ic;
        bus.ic_req_addr  = ia;
        bus.dc_req_valid = do_dc;
        bus.dc_req_we    = dwe;
        bus.dc_req_addr  = da;
        pic = do_ic;
        pdc = do_dc;
        t   = 0;
        while ((pic || pdc) && t < 400) begin
            @(negedge clk);
            dic = pic && bus.ic_req_ready;
            ddc = pdc && bus.dc_req_ready;
            if (ddc) grants.push_back(1);
            if (dic) grants.push_back(0);
            @(posedge clk);
            #1;
            if (dic) begin pic = 1'b0; bus.ic_req_valid = 1'b0; end
            if (ddc) begin pdc = 1'b0; bus.dc_req_valid = 1'b0; end
            t++;
        end
        if (pic || pdc) chk("grant_timeout", (DW+1)'(1), '0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bus.busy && t < 400);
        if (bus.busy) chk("idle_timeout", (DW+1)'(1), '0);
    endtask

    // Transaction-level reference: grant order from the tie rule, then per-line beat lists.
    task automatic check_txn(input bit do_ic, input logic [AW-1:0] ia, input bit do_dc,
                             input bit dwe, input logic [AW-1:0] da);
        int ord[$];
        bit first_dc;
        word_t e_ic_d[$], e_ic_l[$], e_dc_d[$], e_dc_l[$], e_rd[$], e_wa[$], e_wd[$];
        int e_acks;
        logic [AW-1:0] base, a;
        e_acks = 0;
        if (do_ic && do_dc) begin
            first_dc = DC_PRIO || !m_last_dc;
            ord.push_back(first_dc ? 1 : 0);
            ord.push_back(first_dc ? 0 : 1);
        end else begin
            ord.push_back(do_dc ? 1 : 0);
        end
        m_last_dc = (ord[ord.size()-1] == 1);
        chk("grant_count", (DW+1)'(grants.size()), (DW+1)'(ord.size()));
        for (int i = 0; i < ord.size() && i < grants.size(); i++)
            chk("grant_order", (DW+1)'(grants[i]), (DW+1)'(ord[i]));
        foreach (ord[k]) begin
            a    = (ord[k] == 1) ? da : ia;
            base = AW'(a - (a % BEATS));
            for (int i = 0; i < BEATS; i++) begin
                if (ord[k] == 1 && dwe) begin
                    e_wa.push_back(word_t'(AW'(base + i)));
                    e_wd.push_back(wpat(da, i));
                    e_acks++;
                end else begin
                    e_rd.push_back(word_t'(AW'(base + i)));
                    if (ord[k] == 1) begin
                        e_dc_d.push_back(memval(AW'(base + i)));
                        e_dc_l.push_back(word_t'(i == BEATS - 1));
                    end else begin
                        e_ic_d.push_back(memval(AW'(base + i)));
                        e_ic_l.push_back(word_t'(i == BEATS - 1));
                    end
                end
            end
        end
        cmp_q("mem_rd_addr", got_rd_addr, e_rd);
        cmp_q("mem_wr_addr", got_wr_addr, e_wa);
        cmp_q("mem_wr_data", got_wr_data, e_wd);
        cmp_q("ic_rsp_data", got_ic_data, e_ic_d);
        cmp_q("ic_rsp_last", got_ic_last, e_ic_l);
        cmp_q("dc_rsp_data", got_dc_data, e_dc_d);
        cmp_q("dc_rsp_last", got_dc_last, e_dc_l);
        chk("wbeat_acks", (DW+1)'(n_acks), (DW+1)'(e_acks));
        clear_obs();
    endtask

    task automatic clear_obs();
        got_ic_data.delete(); got_ic_last.delete(); got_dc_data.delete(); got_dc_last.delete();
        got_rd_addr.delete(); got_wr_addr.delete(); got_wr_data.delete(); grants.delete();
        n_acks = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs[8];
    bit   bp_pat[6];
    bit   r_di, r_dd, r_we;
    logic [AW-1:0] r_ia, r_da;
    int   t;

    initial begin
        vecs[0] = '{1'b1, 12'h123, 1'b0, 1'b0, 12'h000, 2, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 12'h234, 1'b1, 1'b0, 12'h0A7, 1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h040, 1, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 12'h300, 1'b1, 1'b1, 12'h041, 2, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 12'h011, 1'b1, 1'b0, 12'h080, 3, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h3FF, 1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 12'hFFE, 1'b0, 1'b0, 12'h000, 4, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 12'h555, 1'b1, 1'b1, 12'h777, 1, 1'b0, 1'b1};
        bp_pat  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        bus.ic_req_valid = 1'b0;
        bus.ic_req_addr  = '0;
        bus.dc_req_valid = 1'b0;
        bus.dc_req_we    = 1'b0;
        bus.dc_req_addr  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", (DW+1)'(bus.busy), '0);
        chk("rst_err", (DW+1)'(bus.err), '0);
        chk("rst_mem_req", (DW+1)'({bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr}), '0);
        chk("rst_ready", (DW+1)'({bus.ic_req_ready, bus.dc_req_ready}), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed table.
        for (int r = 0; r < 8; r++) begin
            if (vecs[r].bp) foreach (bp_pat[i]) rdy_pat.push_back(bp_pat[i]);
            issue(vecs[r].do_ic, vecs[r].ia, vecs[r].do_dc, vecs[r].dwe, vecs[r].da,
                  vecs[r].lat, 1'b0);
            if (grants.size() > 0)
                chk("table_first_grant", (DW+1)'(grants[0]), (DW+1)'(vecs[r].exp_first_dc));
            check_txn(vecs[r].do_ic, vecs[r].ia, vecs[r].do_dc, vecs[r].dwe, vecs[r].da);
        end

        // Randomized traffic with random latency and memory backpressure.
        for (int k = 0; k < 30; k++) begin
            r_di = 1'($urandom_range(1));
            r_dd = 1'($urandom_range(1));
            if (!r_di && !r_dd) r_di = 1'b1;
            r_we = 1'($urandom_range(1));
            r_ia = AW'($urandom);
            r_da = AW'($urandom);
            issue(r_di, r_ia, r_dd, r_we, r_da, int'($urandom_range(4, 1)), 1'b1);
            check_txn(r_di, r_ia, r_dd, r_we, r_da);
        end
        rdy_rand = 1'b0;

        // Reset in the middle of an icache read.
        @(posedge clk);
        #1;
        lat = 1;
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 12'h5A2;
        @(negedge clk);
        chk("mid_rst_grant", (DW+1)'(bus.ic_req_ready), (DW+1)'(1));
        @(posedge clk);
        #1;
        bus.ic_req_valid = 1'b0;
        t = 0;
        while (got_ic_data.size() < 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("mid_rst_two_beats", (DW+1)'(got_ic_data.size()), (DW+1)'(2));
        @(posedge clk);
        #1;
        rst = 1'b1;
        pend_addr.delete();
        pend_due.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", (DW+1)'(bus.busy), '0);
        chk("post_rst_mem_req", (DW+1)'({bus.mem_req_valid, bus.mem_req_addr}), '0);
        chk("post_rst_rsp", (DW+1)'({bus.ic_rsp_valid, bus.ic_rsp_last, bus.dc_rsp_valid}), '0);
        clear_obs();
        m_last_dc = 1'b0;
        issue(1'b1, 12'h5A2, 1'b1, 1'b0, 12'h0C4, 2, 1'b0);
        check_txn(1'b1, 12'h5A2, 1'b1, 1'b0, 12'h0C4);

        // Stray memory response while idle.
        @(negedge clk);
        chk("err_before", (DW+1)'(bus.err), '0);
        inject = 1'b1;
        @(negedge clk);
        chk("stray_no_rsp", (DW+1)'({bus.ic_rsp_valid, bus.dc_rsp_valid}), '0);
        @(negedge clk);
        chk("err_set", (DW+1)'(bus.err), (DW+1)'(1));
        repeat (5) @(negedge clk);
        chk("err_sticky", (DW+1)'(bus.err), (DW+1)'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("err_cleared", (DW+1)'(bus.err), '0);
        clear_obs();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
